dff_q_monitor: RTL and testbench

- Downstream consumer of the constant/set-style flop outputs in the sequential-logic-optimization suite.
- Synchronises a single-bit flop output `q_in` and detects its edges.
- Counts rising edges and measures the length of the last high and low runs.
- Flags `q_in` as stuck when it does not toggle within a timeout, so the bench can confirm which flops synthesis reduced to constants.

---
 rtl/dff_q_monitor.sv | 172 +++++++++++++++++
 tb/tb_dff_q_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_q_monitor.sv
// dff_q_monitor: synchronises a flop output, reports edges, run lengths and stuck-at.
// Optional Q_MON_FALL_CNT_EN adds fall_cnt and a rise/fall mismatch stuck check.
module dff_q_monitor #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             clr,
    output logic             q_sync,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
`ifdef Q_MON_FALL_CNT_EN
    output logic [CNT_W-1:0] fall_cnt,
`endif
    output logic             stuck,
    output logic             stuck_val
);

    typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH, S_STUCK} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   stuck_q;
    logic                   stuck_val_q;
    state_e                 state_q;
    logic [IW-1:0]          init_q;
    logic [CNT_W-1:0]       run_q;
    logic [CNT_W-1:0]       rise_cnt_q;
    logic [CNT_W-1:0]       high_len_q;
    logic [CNT_W-1:0]       low_len_q;
    logic                   qs;
    logic                   rise_d;
    logic                   fall_d;
    logic [CNT_W-1:0]       run_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign qs     = sync_q[SYNC_STAGES-1];
    assign rise_d = qs & ~prev_q;
    assign fall_d = ~qs & prev_q;
    assign run_d  = sat_inc(run_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
            prev_q <= qs;
        end
    end

`ifdef Q_MON_FALL_CNT_EN
    logic [CNT_W-1:0] fall_cnt_q;
    logic [CNT_W-1:0] gap;
    logic             mis_q;

    assign gap = (rise_cnt_q >= fall_cnt_q) ? rise_cnt_q - fall_cnt_q
                                            : fall_cnt_q - rise_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else if (clr) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (gap > CNT_W'(1));
        end
    end

    assign fall_cnt = fall_cnt_q;
    assign stuck    = stuck_q | mis_q;
`else
    assign stuck    = stuck_q;
`endif

    // INIT waits for the synchroniser to fill so the starting level is never an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            init_q      <= '0;
            run_q       <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rise_cnt_q  <= '0;
            high_len_q  <= '0;
            low_len_q   <= '0;
            stuck_q     <= 1'b0;
            stuck_val_q <= 1'b0;
`ifdef Q_MON_FALL_CNT_EN
            fall_cnt_q  <= '0;
`endif
        end else if (clr) begin
            state_q     <= S_INIT;
            init_q      <= '0;
            run_q       <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rise_cnt_q  <= '0;
            high_len_q  <= '0;
            low_len_q   <= '0;
            stuck_q     <= 1'b0;
            stuck_val_q <= 1'b0;
`ifdef Q_MON_FALL_CNT_EN
            fall_cnt_q  <= '0;
`endif
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    run_q <= '0;
                    if (init_q == INIT_LAST) begin
                        state_q <= qs ? S_HIGH : S_LOW;
                    end else begin
                        init_q <= init_q + 1'b1;
                    end
                end
                default: begin
                    if (rise_d | fall_d) begin
                        rise_q  <= rise_d;
                        fall_q  <= fall_d;
                        run_q   <= '0;
                        stuck_q <= 1'b0;
                        if (rise_d) begin
                            low_len_q  <= run_d;
                            rise_cnt_q <= sat_inc(rise_cnt_q);
                            state_q    <= S_HIGH;
                        end else begin
                            high_len_q <= run_d;
`ifdef Q_MON_FALL_CNT_EN
                            fall_cnt_q <= sat_inc(fall_cnt_q);
`endif
                            state_q    <= S_LOW;
                        end
                    end else begin
                        run_q <= run_d;
                        if (state_q != S_STUCK && run_q == TO_LAST) begin
                            state_q     <= S_STUCK;
                            stuck_q     <= 1'b1;
                            stuck_val_q <= qs;
                        end
                    end
                end
            endcase
        end
    end

    assign q_sync    = qs;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign rise_cnt  = rise_cnt_q;
    assign high_len  = high_len_q;
    assign low_len   = low_len_q;
    assign stuck_val = stuck_val_q;

endmodule

// File: tb/tb_dff_q_monitor.sv
// Bench for dff_q_monitor: event-level reference model on the default instance,
// plus a CNT_W=4 instance for saturation.
module tb_dff_q_monitor;

    localparam int SYNC = 2;
    localparam int TO   = 1000;
    localparam int MAXC = 65535;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        q_in = 1'b0;
    logic        clr = 1'b0;
    logic        q_sync, rise, fall, stuck, stuck_val;
    logic [15:0] rise_cnt, high_len, low_len;
    logic        q_in2 = 1'b0;
    logic        clr2 = 1'b0;
    logic        q_sync2, rise2, fall2, stuck2, stuck_val2;
    logic [3:0]  rise_cnt2, high_len2, low_len2;
`ifdef Q_MON_FALL_CNT_EN
    logic [15:0] fall_cnt;
    logic [3:0]  fall_cnt2;
`endif

    int tests = 0;
    int fails = 0;

    always #HALF clk = ~clk;

    dff_q_monitor u_dut (
        .clk(clk), .reset(reset), .q_in(q_in), .clr(clr),
        .q_sync(q_sync), .rise(rise), .fall(fall),
        .rise_cnt(rise_cnt), .high_len(high_len), .low_len(low_len),
`ifdef Q_MON_FALL_CNT_EN
        .fall_cnt(fall_cnt),
`endif
        .stuck(stuck), .stuck_val(stuck_val)
    );

    dff_q_monitor #(.CNT_W(4), .TIMEOUT(15), .SYNC_STAGES(2)) u_small (
        .clk(clk), .reset(reset), .q_in(q_in2), .clr(clr2),
        .q_sync(q_sync2), .rise(rise2), .fall(fall2),
        .rise_cnt(rise_cnt2), .high_len(high_len2), .low_len(low_len2),
`ifdef Q_MON_FALL_CNT_EN
        .fall_cnt(fall_cnt2),
`endif
        .stuck(stuck2), .stuck_val(stuck_val2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples of q_in per edge, runs measured as edge-index gaps
    bit smp[$];
    int n, x_edge, start, rc, fc, hl, ll;
    bit e_rise, e_fall, e_st, e_sv, e_mis;

    function automatic bit qsf(input int k);
        int idx;
        idx = k - SYNC;
        if (idx < 0) return 1'b0;
        return smp[idx];
    endfunction

    task automatic mdl_reset();
        n = 0;
        smp.delete();
        x_edge = SYNC + 1;
        start = 0;
        rc = 0; fc = 0; hl = 0; ll = 0;
        e_rise = 0; e_fall = 0; e_st = 0; e_sv = 0; e_mis = 0;
    endtask

    task automatic mdl_step(input bit s_in, input bit c);
        int len;
        bit q1, q2;
        n++;
        smp.push_back(s_in);
        e_rise = 0;
        e_fall = 0;
        if (c) begin
            x_edge = n + SYNC + 1;
            rc = 0; fc = 0; hl = 0; ll = 0;
            e_st = 0; e_sv = 0; e_mis = 0;
        end else begin
            e_mis = (rc > fc + 1) || (fc > rc + 1);
            q1 = qsf(n - 1);
            q2 = qsf(n - 2);
            if (n == x_edge) begin
                start = n;
            end else if (n > x_edge) begin
                if (q1 != q2) begin
                    len = (n - start > MAXC) ? MAXC : n - start;
                    if (q1) begin
                        e_rise = 1; ll = len;
                        if (rc < MAXC) rc++;
                    end else begin
                        e_fall = 1; hl = len;
                        if (fc < MAXC) fc++;
                    end
                    start = n;
                    e_st = 0;
                end else if (!e_st && n - start >= TO) begin
                    e_st = 1;
                    e_sv = q1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit s_in, c_in;
        bit exp_st;
        s_in = q_in;
        c_in = clr;
        if (!reset) mdl_reset();
        else mdl_step(s_in, c_in);
        #1;
        exp_st = e_st;
`ifdef Q_MON_FALL_CNT_EN
        exp_st = e_st | e_mis;
        chk("fall_cnt", fall_cnt, fc);
`endif
        chk("q_sync", q_sync, qsf(n));
        chk("rise", rise, e_rise);
        chk("fall", fall, e_fall);
        chk("rise_cnt", rise_cnt, rc);
        chk("high_len", high_len, hl);
        chk("low_len", low_len, ll);
        chk("stuck", stuck, exp_st);
        chk("stuck_val", stuck_val, e_sv);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t, limit 400000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int r2;
        // constant high input: no edge, stuck after TIMEOUT
        q_in = 1'b1;
        #50;
        @(negedge clk);
        reset = 1'b1;
        repeat (1200) @(negedge clk);
        chk("t1_stuck", stuck, 1);
        chk("t1_stuck_val", stuck_val, 1);
        chk("t1_rise_cnt", rise_cnt, 0);

        // stuck recovery on the fall
        q_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (fall) seen = 1;
        end
        chk("t3_fall_seen", seen, 1);
        chk("t3_stuck_clr", stuck, 0);

        // free-running toggle, asynchronous to clk
        #1;
        repeat (12) #3094 q_in = ~q_in;
        repeat (5) @(negedge clk);
        chk("t2_hl_range", (high_len >= 77 && high_len <= 78), 1);
        chk("t2_ll_range", (low_len >= 77 && low_len <= 78), 1);
        chk("t2_rise_cnt", rise_cnt, 6);

        // clr on the same edge that would count a rise
        repeat (10) @(negedge clk);
        q_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t4_no_pulse", rise, 0);
        chk("t4_cnt_clr", rise_cnt, 0);
        repeat (6) @(negedge clk);
        q_in = 1'b0;
        repeat (6) @(negedge clk);
        q_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_next_rise", rise_cnt, 1);

        // small instance: random-phase warm-up, then saturating toggles
        repeat ($urandom_range(3, 9)) @(negedge clk);
        r2 = 0;
        for (int i = 0; i < 40; i++) begin
            q_in2 = ~q_in2;
            if (q_in2) r2++;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("t5_sat", rise_cnt2, (r2 > 15) ? 15 : r2);
        chk("t5_high_len", high_len2, 2);
        chk("t5_low_len", low_len2, 2);
        chk("t5_stuck", stuck2, 0);
`ifdef Q_MON_FALL_CNT_EN
        chk("t5_fall_sat", fall_cnt2, 15);
`endif

        // asynchronous reset in the middle of a high run
        repeat ($urandom_range(5, 20)) @(negedge clk);
        #5 reset = 1'b0;
        #1;
        chk("t6_q_sync", q_sync, 0);
        chk("t6_rise_cnt", rise_cnt, 0);
        chk("t6_high_len", high_len, 0);
        chk("t6_low_len", low_len, 0);
        chk("t6_stuck_val", stuck_val, 0);
        chk("t6_small_cnt", rise_cnt2, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t6_no_rise", rise, 0);
        end
        chk("t6_q_sync_hi", q_sync, 1);
        chk("t6_cnt_after", rise_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
